// File: rtl/sub86_muldiv_pkg.sv
// rtl/sub86_muldiv_pkg.sv - shared encodings and constants for the sub86 multiply/divide unit
// Holds the OP encoding, the controller state encoding and the width limits.
package sub86_pkg;

    localparam int MAX_WIDTH = 64;
    // Iteration counter must reach MAX_WIDTH-1
    localparam int CNT_W     = $clog2(MAX_WIDTH) + 1;

    typedef enum logic [1:0] {
        OP_MUL  = 2'b00,
        OP_IMUL = 2'b01,
        OP_DIV  = 2'b10,
        OP_IDIV = 2'b11
    } op_t;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PREP = 3'd1,
        S_ITER = 3'd2,
        S_FIX  = 3'd3,
        S_DONE = 3'd4
    } state_t;

endpackage

// File: rtl/sub86_muldiv_if.sv
// rtl/sub86_muldiv_if.sv - request/result bundle of the sub86 multiply/divide unit
// master drives: ce, start, abort, op, a, b
// slave drives : busy, done, lo, hi, dz
interface sub86_muldiv_if #(
    parameter int WIDTH = 32
);
    logic             ce;
    logic             start;
    logic             abort;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] hi;
    logic             dz;

    modport master (
        output ce, start, abort, op, a, b,
        input  busy, done, lo, hi, dz
    );

    modport slave (
        input  ce, start, abort, op, a, b,
        output busy, done, lo, hi, dz
    );
endinterface

// File: rtl/sub86_addsub.sv
// rtl/sub86_addsub.sv - adder/subtractor shared by the multiply and divide datapaths
// a_i, b_i : operands
// sub_i    : 1 = a_i - b_i, 0 = a_i + b_i
// y_o      : result
// co_o     : carry out on add, borrow out on subtract
module sub86_addsub #(
    parameter int WIDTH = 33
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             sub_i,
    output logic [WIDTH-1:0] y_o,
    output logic             co_o
);
    logic [WIDTH:0] sum;

    assign sum  = {1'b0, a_i} + {1'b0, (sub_i ? ~b_i : b_i)} + {{WIDTH{1'b0}}, sub_i};
    assign y_o  = sum[WIDTH-1:0];
    // Subtract yields carry=1 when no borrow; invert to report borrow
    assign co_o = sum[WIDTH] ^ sub_i;
endmodule

// File: rtl/sub86_muldiv.sv
// rtl/sub86_muldiv.sv - iterative signed/unsigned multiply and restoring divide
// clk_i : clock, rst_i : asynchronous active-high reset
// bus   : slave side of sub86_muldiv_if (ce/start/abort/op/a/b in, busy/done/lo/hi/dz out)
module sub86_muldiv
    import sub86_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic          clk_i,
    input  logic          rst_i,
    sub86_muldiv_if.slave bus
);
    state_t               state_q, state_d;
    op_t                  op_q;
    logic [WIDTH-1:0]     acc_q;   // product high half / partial remainder
    logic [WIDTH-1:0]     mq_q;    // multiplier / dividend, becomes product low / quotient
    logic [WIDTH-1:0]     dv_q;    // multiplicand / divisor magnitude
    logic [WIDTH-1:0]     lo_q, hi_q;
    logic [CNT_W-1:0]     cnt_q;
    logic                 sgn_lo_q, sgn_hi_q, dz_q;

    logic                 is_div, is_sgn, a_neg, b_neg;
    logic                 abort_hit, dz_hit, last_iter;
    logic [WIDTH:0]       add_a, add_b, add_y;
    logic                 add_co;
    logic [2*WIDTH-1:0]   prod, prod_neg;

    assign is_div    = (op_q == OP_DIV) || (op_q == OP_IDIV);
    assign is_sgn    = (op_q == OP_IMUL) || (op_q == OP_IDIV);
    assign a_neg     = is_sgn & mq_q[WIDTH-1];
    assign b_neg     = is_sgn & dv_q[WIDTH-1];
    assign dz_hit    = is_div && (dv_q == '0);
    assign last_iter = (cnt_q == CNT_W'(WIDTH - 1));
    assign abort_hit = bus.abort && (state_q inside {S_PREP, S_ITER, S_FIX});
    assign prod      = {acc_q, mq_q};
    assign prod_neg  = -prod;

    // Divide: trial-subtract divisor from remainder shifted left by one dividend bit.
    // Multiply: add multiplicand to the high half when the current multiplier bit is set.
    always_comb begin
        add_a = {1'b0, acc_q};
        add_b = '0;
        if (is_div) begin
            add_a = {acc_q, mq_q[WIDTH-1]};
            add_b = {1'b0, dv_q};
        end else if (mq_q[0]) begin
            add_b = {1'b0, dv_q};
        end
    end

    sub86_addsub #(.WIDTH(WIDTH + 1)) u_addsub (
        .a_i  (add_a),
        .b_i  (add_b),
        .sub_i(is_div),
        .y_o  (add_y),
        .co_o (add_co)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (bus.start) state_d = S_PREP;
            S_PREP:  state_d = dz_hit ? S_DONE : S_ITER;
            S_ITER:  if (last_iter) state_d = S_FIX;
            S_FIX:   state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (abort_hit) state_d = S_IDLE;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            op_q     <= OP_MUL;
            acc_q    <= '0;
            mq_q     <= '0;
            dv_q     <= '0;
            lo_q     <= '0;
            hi_q     <= '0;
            cnt_q    <= '0;
            sgn_lo_q <= 1'b0;
            sgn_hi_q <= 1'b0;
            dz_q     <= 1'b0;
        end else if (bus.ce) begin
            state_q <= state_d;
            case (state_q)
                S_IDLE: if (bus.start) begin
                    op_q <= op_t'(bus.op);
                    mq_q <= bus.a;
                    dv_q <= bus.b;
                end
                S_PREP: if (!abort_hit) begin
                    acc_q    <= '0;
                    cnt_q    <= '0;
                    sgn_lo_q <= a_neg ^ b_neg;
                    sgn_hi_q <= is_div ? a_neg : (a_neg ^ b_neg);
                    if (dz_hit) begin
                        // Raw dividend is still in mq_q here
                        lo_q <= '1;
                        hi_q <= mq_q;
                        dz_q <= 1'b1;
                    end else begin
                        mq_q <= a_neg ? -mq_q : mq_q;
                        dv_q <= b_neg ? -dv_q : dv_q;
                    end
                end
                S_ITER: if (!abort_hit) begin
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (is_div) begin
                        if (!add_co) begin
                            acc_q <= add_y[WIDTH-1:0];
                            mq_q  <= {mq_q[WIDTH-2:0], 1'b1};
                        end else begin
                            acc_q <= add_a[WIDTH-1:0];
                            mq_q  <= {mq_q[WIDTH-2:0], 1'b0};
                        end
                    end else begin
                        acc_q <= add_y[WIDTH:1];
                        mq_q  <= {add_y[0], mq_q[WIDTH-1:1]};
                    end
                end
                S_FIX: if (!abort_hit) begin
                    dz_q <= 1'b0;
                    if (is_div) begin
                        lo_q <= sgn_lo_q ? -mq_q : mq_q;
                        hi_q <= sgn_hi_q ? -acc_q : acc_q;
                    end else begin
                        {hi_q, lo_q} <= sgn_lo_q ? prod_neg : prod;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy = (state_q != S_IDLE);
    assign bus.done = (state_q == S_DONE);
    assign bus.lo   = lo_q;
    assign bus.hi   = hi_q;
    assign bus.dz   = dz_q;
endmodule

// File: tb/tb_sub86_muldiv.sv
// tb/tb_sub86_muldiv.sv - self-checking bench for sub86_muldiv (WIDTH 32 and 8 instances)
module tb_sub86_muldiv;
    import sub86_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sub86_muldiv_if #(.WIDTH(32)) i32 ();
    sub86_muldiv_if #(.WIDTH(8))  i8 ();

    sub86_muldiv #(.WIDTH(32)) u_dut32 (.clk_i(clk), .rst_i(rst), .bus(i32));
    sub86_muldiv #(.WIDTH(8))  u_dut8  (.clk_i(clk), .rst_i(rst), .bus(i8));

    int n_chk  = 0;
    int n_fail = 0;
    int lat    = 0;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a, b, lo, hi;
        logic        dz;
        int          lat;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic [1:0] op, logic [31:0] a, logic [31:0] b,
                                logic [31:0] lo, logic [31:0] hi, logic dz, int l);
        vec_t v;
        v.op = op; v.a = a; v.b = b; v.lo = lo; v.hi = hi; v.dz = dz; v.lat = l;
        return v;
    endfunction

    // Arithmetic reference: exact integer multiply/divide on w-bit operands
    function automatic void model(input int w, input logic [1:0] op, input logic [31:0] a,
                                  input logic [31:0] b, output logic [31:0] lo,
                                  output logic [31:0] hi, output logic dz);
        logic [63:0] m;
        longint      sa, sb, p, q, r;
        m  = (64'd1 << w) - 64'd1;
        sa = longint'({32'b0, a} & m);
        sb = longint'({32'b0, b} & m);
        if (op[0] && a[w-1]) sa = sa - (longint'(1) <<< w);
        if (op[0] && b[w-1]) sb = sb - (longint'(1) <<< w);
        dz = 1'b0;
        if (!op[1]) begin
            p  = sa * sb;
            lo = 32'(64'(p) & m);
            hi = 32'((64'(p) >> w) & m);
        end else if (sb == 0) begin
            dz = 1'b1;
            lo = 32'(m);
            hi = 32'({32'b0, a} & m);
        end else begin
            q  = sa / sb;
            r  = sa % sb;
            lo = 32'(64'(q) & m);
            hi = 32'(64'(r) & m);
        end
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    // Issues START for one cycle, then scrambles inputs to prove they were latched
    task automatic start_op(input bit w8, input logic [1:0] op, input logic [31:0] a,
                            input logic [31:0] b);
        int k = 0;
        @(negedge clk);
        while ((w8 ? i8.busy : i32.busy) && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (w8) begin
            i8.op = op; i8.a = a[7:0]; i8.b = b[7:0]; i8.start = 1'b1;
        end else begin
            i32.op = op; i32.a = a; i32.b = b; i32.start = 1'b1;
        end
        @(posedge clk);
        #1;
        i8.start  = 1'b0;
        i32.start = 1'b0;
        i8.op  = 2'($urandom); i8.a  = 8'($urandom); i8.b  = 8'($urandom);
        i32.op = 2'($urandom); i32.a = $urandom;     i32.b = $urandom;
        lat = 1;
    endtask

    task automatic wait_done(input bit w8);
        while (!(w8 ? i8.done : i32.done) && lat < 300) step(1);
    endtask

    task automatic check_res(input string nm, input bit w8, input logic [31:0] lo,
                             input logic [31:0] hi, input logic dz, input int elat);
        chk({nm, " latency"}, 64'(lat), 64'(elat));
        chk({nm, " lo"}, w8 ? {56'b0, i8.lo} : {32'b0, i32.lo}, {32'b0, lo});
        chk({nm, " hi"}, w8 ? {56'b0, i8.hi} : {32'b0, i32.hi}, {32'b0, hi});
        chk({nm, " dz"}, 64'(w8 ? i8.dz : i32.dz), 64'(dz));
        step(1);
        chk({nm, " done_pulse"}, 64'(w8 ? i8.done : i32.done), 64'd0);
    endtask

    initial begin
        logic [1:0]  op;
        logic [31:0] a, b, elo, ehi, plo, phi;
        logic        edz, pdz;
        int          seen;

        i32.ce = 1'b0; i32.start = 1'b0; i32.abort = 1'b0; i32.op = 2'b00; i32.a = '0; i32.b = '0;
        i8.ce  = 1'b0; i8.start  = 1'b0; i8.abort  = 1'b0; i8.op  = 2'b00; i8.a  = '0; i8.b  = '0;

        // Reset state with CE low
        repeat (2) @(negedge clk);
        chk("rst busy", 64'(i32.busy), 64'd0);
        chk("rst done", 64'(i32.done), 64'd0);
        chk("rst lo",   64'(i32.lo),   64'd0);
        chk("rst hi",   64'(i32.hi),   64'd0);
        chk("rst dz",   64'(i32.dz),   64'd0);
        chk("rst w8 lo", 64'(i8.lo),   64'd0);
        rst = 1'b0;
        i32.ce = 1'b1;
        i8.ce  = 1'b1;

        vecs.push_back(mk(OP_MUL,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFE, 1'b0, 35));
        vecs.push_back(mk(OP_IMUL, 32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFEB, 32'hFFFF_FFFF, 1'b0, 35));
        vecs.push_back(mk(OP_IDIV, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 35));
        vecs.push_back(mk(OP_IDIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0000, 1'b0, 35));
        vecs.push_back(mk(OP_DIV,  32'd100,       32'd0,         32'hFFFF_FFFF, 32'h0000_0064, 1'b1, 2));
        vecs.push_back(mk(OP_DIV,  32'd100,       32'd7,         32'd14,        32'd2,         1'b0, 35));
        for (int k = 0; k < 24; k++) begin
            op = 2'($urandom_range(0, 3));
            a  = (k % 8 == 7) ? 32'h8000_0000 : $urandom;
            b  = (k % 6 == 0) ? 32'd0 : ((k % 3 == 0) ? 32'($urandom_range(1, 15)) : $urandom);
            model(32, op, a, b, elo, ehi, edz);
            vecs.push_back(mk(op, a, b, elo, ehi, edz, edz ? 2 : 35));
        end

        foreach (vecs[i]) begin
            start_op(1'b0, vecs[i].op, vecs[i].a, vecs[i].b);
            wait_done(1'b0);
            check_res($sformatf("vec%0d", i), 1'b0, vecs[i].lo, vecs[i].hi, vecs[i].dz, vecs[i].lat);
        end

        // CE held low for 10 cycles during ITER
        start_op(1'b0, OP_DIV, 32'd100, 32'd7);
        step(4);
        i32.ce = 1'b0;
        step(10);
        i32.ce = 1'b1;
        wait_done(1'b0);
        check_res("ce_stall", 1'b0, 32'd14, 32'd2, 1'b0, 45);

        // START while busy is ignored
        model(32, OP_MUL, 32'hFFFF_FFFF, 32'd2, plo, phi, pdz);
        start_op(1'b0, OP_MUL, 32'hFFFF_FFFF, 32'd2);
        step(4);
        i32.start = 1'b1; i32.op = OP_DIV; i32.a = 32'd1; i32.b = 32'd0;
        step(1);
        i32.start = 1'b0;
        wait_done(1'b0);
        check_res("busy_start", 1'b0, plo, phi, pdz, 35);
        step(3);
        chk("busy_start idle", 64'(i32.busy), 64'd0);

        // ABORT in ITER: idle next edge, no DONE, outputs unchanged
        start_op(1'b0, OP_IDIV, 32'hFFFF_FF00, 32'd3);
        step(4);
        i32.abort = 1'b1;
        step(1);
        i32.abort = 1'b0;
        chk("abort busy", 64'(i32.busy), 64'd0);
        seen = 0;
        repeat (40) begin
            step(1);
            if (i32.done) seen++;
        end
        chk("abort no_done", 64'(seen), 64'd0);
        chk("abort lo", 64'(i32.lo), 64'(plo));
        chk("abort hi", 64'(i32.hi), 64'(phi));
        chk("abort dz", 64'(i32.dz), 64'(pdz));

        // RST asserted mid-ITER clears outputs immediately
        start_op(1'b0, OP_MUL, 32'h1234_5678, 32'h9ABC_DEF0);
        step(4);
        rst = 1'b1;
        #1;
        chk("midrst busy", 64'(i32.busy), 64'd0);
        chk("midrst done", 64'(i32.done), 64'd0);
        chk("midrst lo",   64'(i32.lo),   64'd0);
        chk("midrst hi",   64'(i32.hi),   64'd0);
        chk("midrst dz",   64'(i32.dz),   64'd0);
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        repeat (40) begin
            step(1);
            if (i32.done) seen++;
        end
        chk("midrst no_done", 64'(seen), 64'd0);

        // WIDTH=8 instance
        start_op(1'b1, OP_MUL, 32'hFF, 32'hFF);
        wait_done(1'b1);
        check_res("w8 mul", 1'b1, 32'h01, 32'hFE, 1'b0, 11);
        start_op(1'b1, OP_IDIV, 32'h80, 32'hFF);
        wait_done(1'b1);
        check_res("w8 idiv", 1'b1, 32'h80, 32'h00, 1'b0, 11);
        for (int k = 0; k < 8; k++) begin
            op = 2'(k % 4);
            a  = 32'($urandom_range(0, 255));
            b  = (k == 6) ? 32'd0 : 32'($urandom_range(0, 255));
            model(8, op, a, b, elo, ehi, edz);
            start_op(1'b1, op, a, b);
            wait_done(1'b1);
            check_res($sformatf("w8 rnd%0d", k), 1'b1, elo, ehi, edz, edz ? 2 : 11);
        end

        // Recovery after mid-operation reset
        start_op(1'b0, OP_DIV, 32'd100, 32'd7);
        wait_done(1'b0);
        check_res("recover", 1'b0, 32'd14, 32'd2, 1'b0, 35);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/sub86_muldiv.md
SUB86_MULDIV -- requirements
Module: sub86_muldiv

Interface
REQ-001 The block SHALL have one parameter: WIDTH, default 32, operand width in bits, legal range 4..64.
REQ-002 CLK  in  1  single clock; all state SHALL change on its rising edge.
REQ-003 RST  in  1  reset, asynchronous, active-high.
REQ-004 CE  in  1  clock enable; when 0, all registers SHALL hold.
REQ-005 START  in  1  request a new operation; sampled only in IDLE with CE=1.
REQ-006 ABORT  in  1  cancel the operation in progress.
REQ-007 OP  in  2  operation: 00 MUL unsigned, 01 IMUL signed, 10 DIV unsigned, 11 IDIV signed.
REQ-008 A  in  WIDTH  multiplicand or dividend.
REQ-009 B  in  WIDTH  multiplier or divisor.
REQ-010 BUSY  out  1  high in every state except IDLE.
REQ-011 DONE  out  1  one-cycle pulse marking valid results.
REQ-012 LO  out  WIDTH  product low half or quotient.
REQ-013 HI  out  WIDTH  product high half or remainder.
REQ-014 DZ  out  1  divide-by-zero flag for the last completed operation.

Function
REQ-015 States SHALL be IDLE, PREP, ITER, FIX and DONE.
- IDLE->PREP on START.
- PREP->ITER, or PREP->DONE on divide-by-zero.
- ITER->FIX after WIDTH iterations.
- FIX->DONE; DONE->IDLE.
REQ-016 On an accepted START, A, B and OP SHALL be latched; later changes to these inputs SHALL NOT affect the operation in progress.
REQ-017 In PREP with OP[0]=1, operands SHALL be converted to magnitudes and the result signs recorded: product sign A^B, quotient sign A^B, remainder sign A.
REQ-018 ITER SHALL process exactly one bit per enabled cycle, counted by an internal counter.
- Multiply: shift-add.
- Divide: restoring division using a WIDTH+1-bit subtract.
REQ-019 In FIX, results SHALL be two's-complement negated where a recorded sign requires it.
- Multiply negation is over the full 2*WIDTH product.
- LO, HI and DZ SHALL be written in FIX only.
REQ-020 DONE SHALL be 1 during the DONE state; latency is WIDTH+3 enabled edges from the edge that samples START.
REQ-021 Multiply results: {HI,LO} SHALL be the exact 2*WIDTH-bit product, signed or unsigned per OP.
REQ-022 Signed divide SHALL truncate toward zero, and the remainder SHALL take the sign of the dividend.
REQ-023 IDIV of the most-negative value by -1 SHALL give LO = most-negative value and HI = 0, with no flag raised.
REQ-024 Divide with B=0 SHALL behave as follows.
- PREP goes directly to DONE; latency is 2 enabled edges from the START edge.
- DZ=1, LO=all ones, HI=A unchanged.
REQ-025 DZ SHALL be cleared by any operation that completes without divide-by-zero.
REQ-026 START while BUSY=1 SHALL be ignored.
REQ-027 ABORT with CE=1 in PREP, ITER or FIX SHALL return the block to IDLE at the next edge.
- DONE is not pulsed, and LO, HI and DZ keep their prior values.
- ABORT has priority over START in the same cycle.
- ABORT in IDLE or DONE has no effect.
REQ-028 LO, HI and DZ SHALL hold their last values until the next operation completes.

Reset
REQ-029 While RST=1, the block SHALL be in IDLE with BUSY=0, DONE=0, LO=0, HI=0, DZ=0, and the iteration counter at 0, regardless of CE.
REQ-030 When RST asserts mid-operation, the operation SHALL be discarded with no DONE pulse.

Structure
REQ-031 Package sub86_pkg SHALL hold the OP encodings, the state encoding, and the maximum-WIDTH constant.
REQ-032 A single sub-module, sub86_addsub (parametrised WIDTH+1 adder/subtractor with carry/borrow out), SHALL be shared by the multiply and divide datapaths; all other logic stays in sub86_muldiv.

Verification
REQ-033 MUL, WIDTH=32, A=B=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001, DZ=0; DONE exactly 35 edges after the START edge.
REQ-034 IMUL A=0xFFFFFFFD (-3), B=7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB (-21).
REQ-035 IDIV A=0xFFFFFFF9 (-7), B=2 -> LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1); IDIV A=0x80000000, B=0xFFFFFFFF -> LO=0x80000000, HI=0.
REQ-036 DIV A=100, B=0 -> DZ=1, LO=0xFFFFFFFF, HI=0x00000064, DONE 2 edges after START; a following DIV 100/7 -> LO=14, HI=2, DZ=0.
REQ-037 Control scenario:
- Start DIV 100/7, then hold CE=0 for 10 cycles in ITER: latency extends by exactly 10 and results are unchanged.
- START pulsed while BUSY: ignored.
- ABORT in ITER: IDLE next edge, no DONE, outputs unchanged.
- RST asserted mid-ITER: all outputs 0 immediately.
REQ-038 WIDTH=8 regression: MUL 0xFF*0xFF -> HI=0xFE, LO=0x01, DONE 11 edges after START; IDIV 0x80 / 0xFF -> LO=0x80, HI=0x00.
